// File: rtl/line_clear_unit.sv
// Row-elimination and scoring engine: scans a locked board bottom-up, removes
// full rows one per cycle, compacts the rows above and keeps a saturating BCD score.
module line_clear_unit #(
  parameter int COLS   = 12,
  parameter int ROWS   = 12,
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COLS*ROWS-1:0]   board_in,
  input  logic                   score_clr,
  output logic                   busy,
  output logic                   done,
  output logic [COLS*ROWS-1:0]   board_out,
  output logic [3:0]             lines_cleared,
  output logic [4*DIGITS-1:0]    score_bcd,
  output logic [1:0]             state_dbg
);

  localparam int N     = COLS * ROWS;
  localparam int IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        work_q, work_d;
  logic [IDX_W-1:0]    row_idx_q, row_idx_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [N-1:0]        board_out_q, board_out_d;
  logic [3:0]          lines_q, lines_d;
  logic [4*DIGITS-1:0] score_q, score_d;

  logic [COLS-1:0]     row_cur;
  logic                row_full;
  logic [N-1:0]        shifted;

  // Current row selection and the board with the current row removed
  // (everything above it drops by one, a blank row enters at the top).
  always_comb begin
    row_cur = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (IDX_W'(r) == row_idx_q) row_cur = work_q[r*COLS +: COLS];
    end
    row_full = &row_cur;
    shifted  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (IDX_W'(r) > row_idx_q)
        shifted[r*COLS +: COLS] = work_q[r*COLS +: COLS];
      else if (r == 0)
        shifted[0 +: COLS] = '0;
      else
        shifted[r*COLS +: COLS] = work_q[(r-1)*COLS +: COLS];
    end
  end

  logic [3:0]          add_units, add_tens, addend;
  logic [4:0]          dsum;
  logic                carry;
  logic [4*DIGITS-1:0] score_sum;

  // Ripple BCD add of cnt (split into tens/units); carry out of the top digit saturates.
  always_comb begin
    add_units = cnt_q;
    add_tens  = 4'd0;
    if (cnt_q >= 4'd10) begin
      add_units = cnt_q - 4'd10;
      add_tens  = 4'd1;
    end
    carry     = 1'b0;
    addend    = 4'd0;
    dsum      = 5'd0;
    score_sum = '0;
    for (int d = 0; d < DIGITS; d++) begin
      addend = (d == 0) ? add_units : ((d == 1) ? add_tens : 4'd0);
      dsum   = {1'b0, score_q[d*4 +: 4]} + {1'b0, addend} + {4'b0, carry};
      if (dsum > 5'd9) begin
        score_sum[d*4 +: 4] = 4'(dsum - 5'd10);
        carry               = 1'b1;
      end else begin
        score_sum[d*4 +: 4] = dsum[3:0];
        carry               = 1'b0;
      end
    end
    if (carry) score_sum = {DIGITS{4'd9}};
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    board_out_d = board_out_q;
    lines_d     = lines_q;
    score_d     = score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d    = board_in;
          row_idx_d = IDX_W'(ROWS - 1);
          cnt_d     = 4'd0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (row_full) begin
          work_d = shifted;
          cnt_d  = cnt_q + 4'd1;
        end else if (row_idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          row_idx_d = row_idx_q - 1'b1;
        end
      end
      S_DONE: begin
        board_out_d = work_q;
        lines_d     = cnt_q;
        score_d     = score_sum;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new-game clear overrides any add landing on the same edge.
    if (score_clr) score_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      board_out_q <= '0;
      lines_q     <= '0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      board_out_q <= board_out_d;
      lines_q     <= lines_d;
      score_q     <= score_d;
    end
  end

  assign busy          = (state_q == S_SCAN);
  assign done          = done_q;
  assign board_out     = board_out_q;
  assign lines_cleared = lines_q;
  assign score_bcd     = score_q;
  assign state_dbg     = state_q;

endmodule
